// File: rtl/half_adder_unit.sv
`default_nettype none
// ============================================================================
// Module      : half_adder_unit
// Description : Bitwise half adder. Each of WIDTH lanes is independent:
//               Sum[i] = A[i] ^ B[i], Carry[i] = A[i] & B[i]. The result is
//               available combinationally and, when OUT_REG=1, also as a
//               registered copy with a valid flag for pipelined consumers.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset (registered side only)
//               A, B     - operands, one bit per lane
//               in_valid - A/B qualified this cycle
//               Sum      - combinational A ^ B
//               Carry    - combinational A & B
//               Sum_q    - registered Sum (updates only when in_valid=1)
//               Carry_q  - registered Carry (updates only when in_valid=1)
//               valid_q  - registered in_valid
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder_unit #(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Carry,
  output logic [WIDTH-1:0] Sum_q,
  output logic [WIDTH-1:0] Carry_q,
  output logic             valid_q
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;

  // Plain vector operators keep X/Z propagation per lane exactly as the
  // language defines it; no masking of unknowns is attempted.
  assign w_sum   = A ^ B;
  assign w_carry = A & B;

  assign Sum   = w_sum;
  assign Carry = w_carry;

  generate
    if (OUT_REG) begin : g_out_reg
      logic [WIDTH-1:0] r_sum;
      logic [WIDTH-1:0] r_carry;
      logic             r_valid;

      // valid follows in_valid every cycle; the data registers only load on
      // a qualified cycle so the last good result stays visible downstream.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sum   <= '0;
          r_carry <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= in_valid;
          if (in_valid) begin
            r_sum   <= w_sum;
            r_carry <= w_carry;
          end
        end
      end

      assign Sum_q   = r_sum;
      assign Carry_q = r_carry;
      assign valid_q = r_valid;
    end else begin : g_no_out_reg
      // Registered side removed; clk and rst_n are intentionally unused here.
      assign Sum_q   = '0;
      assign Carry_q = '0;
      assign valid_q = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_half_adder_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_half_adder_unit
// Description : Scoreboard bench for half_adder_unit. Stimulus checks the
//               combinational outputs and queues one record per driven cycle;
//               a monitor pops a record after every clock edge and checks the
//               registered outputs of a WIDTH=4 and a WIDTH=1 instance, plus
//               the tied-off outputs of an OUT_REG=0 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_half_adder_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       iv;

  always #5 clk = ~clk;

  logic [3:0] sum4, car4, sumq4, carq4;
  logic       vq4;
  logic [0:0] sum1, car1, sumq1, carq1;
  logic       vq1;
  logic [3:0] sum0, car0, sumq0, carq0;
  logic       vq0;

  half_adder_unit #(.WIDTH(4), .OUT_REG(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .in_valid(iv),
    .Sum(sum4), .Carry(car4), .Sum_q(sumq4), .Carry_q(carq4), .valid_q(vq4)
  );

  half_adder_unit #(.WIDTH(1), .OUT_REG(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .A(a[0:0]), .B(b[0:0]), .in_valid(iv),
    .Sum(sum1), .Carry(car1), .Sum_q(sumq1), .Carry_q(carq1), .valid_q(vq1)
  );

  half_adder_unit #(.WIDTH(4), .OUT_REG(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .in_valid(iv),
    .Sum(sum0), .Carry(car0), .Sum_q(sumq0), .Carry_q(carq0), .valid_q(vq0)
  );

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic [3:0] c;
  } rec_t;

  rec_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Expected registered contents, maintained by the monitor.
  logic [3:0] m_s = 4'b0;
  logic [3:0] m_c = 4'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_comb(input logic [3:0] es, input logic [3:0] ec);
    chk("sum4",  {4'b0, sum4}, {4'b0, es});
    chk("carry4",{4'b0, car4}, {4'b0, ec});
    chk("sum1",  {7'b0, sum1}, {7'b0, es[0]});
    chk("carry1",{7'b0, car1}, {7'b0, ec[0]});
    chk("sum0",  {4'b0, sum0}, {4'b0, es});
    chk("carry0",{4'b0, car0}, {4'b0, ec});
  endtask

  // Apply one cycle of stimulus at the falling edge, check the combinational
  // result, and queue what the registered side must show after the next edge.
  task automatic drive(input logic [3:0] ta, input logic [3:0] tb_, input logic tv,
                       input logic [3:0] es, input logic [3:0] ec);
    rec_t r;
    @(negedge clk);
    a  = ta;
    b  = tb_;
    iv = tv;
    #1;
    chk_comb(es, ec);
    r.v = tv;
    r.s = es;
    r.c = ec;
    q.push_back(r);
  endtask

  task automatic idle();
    @(negedge clk);
    iv = 1'b0;
    a  = 4'b0;
    b  = 4'b0;
  endtask

  always @(negedge rst_n) begin
    m_s = 4'b0;
    m_c = 4'b0;
  end

  // Monitor: after every rising edge out of reset, pop the record for the
  // cycle just captured (none queued means an idle cycle with in_valid=0).
  initial begin
    rec_t r;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (q.size() > 0) begin
          r = q.pop_front();
        end else begin
          r.v = 1'b0;
          r.s = 4'b0;
          r.c = 4'b0;
        end
        chk("valid_q4", {7'b0, vq4}, {7'b0, r.v});
        chk("valid_q1", {7'b0, vq1}, {7'b0, r.v});
        if (r.v) begin
          m_s = r.s;
          m_c = r.c;
        end
        chk("sum_q4",   {4'b0, sumq4}, {4'b0, m_s});
        chk("carry_q4", {4'b0, carq4}, {4'b0, m_c});
        chk("sum_q1",   {7'b0, sumq1}, {7'b0, m_s[0]});
        chk("carry_q1", {7'b0, carq1}, {7'b0, m_c[0]});
        chk("regs_off0", {sumq0, carq0}, 8'b0);
        chk("valid_off0", {7'b0, vq0}, 8'b0);
      end
    end
  end

  initial begin
    logic [3:0] ra, rb, es, ec;
    logic       rv;
    logic [1:0] lane;

    rst_n = 1'b0;
    iv    = 1'b0;
    a     = 4'b0;
    b     = 4'b0;

    // Reset state before any clock edge.
    #2;
    chk("rst_sumq",  {sumq4, carq4}, 8'b0);
    chk("rst_valid", {6'b0, vq4, vq1}, 8'b0);

    // Reset hold across an edge with live inputs.
    a  = 4'b1111;
    b  = 4'b1111;
    iv = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_hold_q", {sumq4, carq4}, 8'b0);
    chk("rst_hold_v", {6'b0, vq4, vq1}, 8'b0);
    @(negedge clk);
    iv    = 1'b0;
    rst_n = 1'b1;

    // Exhaustive single-lane table: 00,01,10,11 -> S/C 0/0,1/0,1/0,0/1.
    drive(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
    drive(4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b0000);
    drive(4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000);
    drive(4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001);

    // Multi-lane vector: lanes must not interact.
    drive(4'b1100, 4'b1010, 1'b1, 4'b0110, 4'b1000);
    drive(4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b1111);

    // Hold: load 1+1, then an unqualified 0+1 must not update the registers.
    drive(4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001);
    drive(4'b0000, 4'b0001, 1'b0, 4'b0001, 4'b0000);

    // Mid-run asynchronous reset between edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    a     = 4'b1111;
    b     = 4'b0101;
    iv    = 1'b1;
    #1;
    chk("midrst_q", {sumq4, carq4}, 8'b0);
    chk("midrst_v", {6'b0, vq4, vq1}, 8'b0);
    chk_comb(4'b1010, 4'b0101);
    @(posedge clk);
    #1;
    chk("midrst_hold", {sumq4, carq4}, 8'b0);
    @(negedge clk);
    rst_n = 1'b1;
    iv    = 1'b0;
    a     = 4'b0;
    b     = 4'b0;

    // Random traffic; expected values from per-lane arithmetic A+B.
    for (int n = 0; n < 1000; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rv = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        lane  = {1'b0, ra[i]} + {1'b0, rb[i]};
        es[i] = lane[0];
        ec[i] = lane[1];
      end
      drive(ra, rb, rv, es, ec);
    end

    idle();
    @(posedge clk);
    #2;
    chk("queue_empty", 8'(q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
